// File: rtl/memory_stage.sv
// memory_stage: data-memory access stage between execute and writeback.
// Issues loads/stores on a req/gnt/rvalid bus, aligns and extends load data,
// and forwards non-memory ALU results unchanged. One op in flight at a time.
module memory_stage #(
  parameter int ADDR_WIDTH    = 32,
  parameter int DATA_WIDTH    = 32,
  parameter int NUM_REGISTERS = 32,
  localparam int REGISTER_INDEXING_WIDTH = $clog2(NUM_REGISTERS)
) (
  input  logic                               clk,
  input  logic                               rst_n,
  // upstream handshake
  output logic                               stall_prev,
  input  logic                               prev_done,
  // downstream handshake
  input  logic                               next_stall,
  output logic                               done_next,
  // op from execute
  input  logic [ADDR_WIDTH-1:0]              program_count_in,
  input  logic                               load_in,
  input  logic                               store_in,
  input  logic [2:0]                         funct_3_in,
  input  logic [DATA_WIDTH-1:0]              result_data_in,
  input  logic                               result_data_valid_in,
  input  logic [DATA_WIDTH-1:0]              memory_store_data_in,
  input  logic [REGISTER_INDEXING_WIDTH-1:0] write_register_in,
  input  logic                               write_register_valid_in,
  // op to writeback
  output logic [ADDR_WIDTH-1:0]              program_count_out,
  output logic [REGISTER_INDEXING_WIDTH-1:0] write_register_out,
  output logic                               write_register_valid_out,
  output logic [DATA_WIDTH-1:0]              writeback_data_out,
  output logic                               writeback_data_valid_out,
  output logic                               exception_out,
  output logic [1:0]                         exception_cause_out,
  // data-memory bus
  output logic                               mem_req,
  output logic                               mem_we,
  output logic [ADDR_WIDTH-1:0]              mem_addr,
  output logic [DATA_WIDTH-1:0]              mem_wdata,
  output logic [3:0]                         mem_be,
  input  logic                               mem_gnt,
  input  logic                               mem_rvalid,
  input  logic [DATA_WIDTH-1:0]              mem_rdata,
  input  logic                               mem_err
);

  typedef enum logic [1:0] {S_EMPTY, S_ISSUE, S_WAIT, S_READY} state_t;

  localparam logic [1:0] CAUSE_NONE     = 2'd0;
  localparam logic [1:0] CAUSE_MISALIGN = 2'd1;
  localparam logic [1:0] CAUSE_ACCESS   = 2'd2;
  localparam logic [1:0] CAUSE_ILLEGAL  = 2'd3;

  state_t r_state;
  state_t w_next_state;
  state_t w_accept_state;

  logic                  w_transfer_prev;
  logic                  w_transfer_next;
  logic                  w_is_mem;
  logic                  w_illegal;
  logic                  w_misaligned;

  logic                  r_store;
  logic [2:0]            r_funct3;
  logic [ADDR_WIDTH-1:0] r_ea;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [3:0]            r_be;
  logic                  r_wr_valid_in;

  // Shift store data into the byte lane(s) selected by the low address bits.
  function automatic logic [31:0] f_store_lanes(input logic [2:0] f3, input logic [1:0] lo,
                                                input logic [31:0] data);
    logic [4:0] shamt;
    shamt = {lo, 3'b000};
    case (f3)
      3'd0:    f_store_lanes = {24'd0, data[7:0]} << shamt;
      3'd1:    f_store_lanes = {16'd0, data[15:0]} << shamt;
      default: f_store_lanes = data;
    endcase
  endfunction

  // Byte enables: loads always read the whole word.
  function automatic logic [3:0] f_byte_en(input logic is_store, input logic [2:0] f3,
                                           input logic [1:0] lo);
    if (!is_store)       f_byte_en = 4'hF;
    else if (f3 == 3'd0) f_byte_en = 4'b0001 << lo;
    else if (f3 == 3'd1) f_byte_en = 4'b0011 << lo;
    else                 f_byte_en = 4'hF;
  endfunction

  // Select the addressed lane of the response word and sign/zero-extend it.
  function automatic logic [31:0] f_load_extend(input logic [2:0] f3, input logic [1:0] lo,
                                                input logic [31:0] rdata);
    logic [31:0]        sh;
    logic signed [7:0]  sb;
    logic signed [15:0] shw;
    sh  = rdata >> {lo, 3'b000};
    sb  = sh[7:0];
    shw = sh[15:0];
    case (f3)
      3'd0:    f_load_extend = 32'(sb);
      3'd1:    f_load_extend = 32'(shw);
      3'd4:    f_load_extend = {24'd0, sh[7:0]};
      3'd5:    f_load_extend = {16'd0, sh[15:0]};
      default: f_load_extend = sh;
    endcase
  endfunction

  assign w_transfer_next = done_next && !next_stall;
  assign stall_prev      = !rst_n || ((r_state != S_EMPTY) && !w_transfer_next);
  assign w_transfer_prev = prev_done && !stall_prev;

  assign done_next = (r_state == S_READY);
  assign mem_req   = (r_state == S_ISSUE);
  assign mem_we    = mem_req && r_store;
  assign mem_addr  = mem_req ? {r_ea[ADDR_WIDTH-1:2], 2'b00} : '0;
  assign mem_wdata = mem_req ? r_wdata : '0;
  assign mem_be    = mem_req ? r_be : 4'd0;

  assign w_is_mem  = load_in || store_in;

  // Classify the incoming op: illegal size codes, misalignment, and the state it enters.
  always_comb begin
    w_illegal      = 1'b0;
    w_misaligned   = 1'b0;
    w_accept_state = S_READY;
    if (store_in) w_illegal = (funct_3_in >= 3'd3);
    else          w_illegal = (funct_3_in == 3'd3) || (funct_3_in == 3'd6) || (funct_3_in == 3'd7);
    if (funct_3_in[1:0] == 2'd1)      w_misaligned = result_data_in[0];
    else if (funct_3_in[1:0] == 2'd2) w_misaligned = (result_data_in[1:0] != 2'd0);
    if (w_is_mem && result_data_valid_in && !w_illegal && !w_misaligned)
      w_accept_state = S_ISSUE;
  end

  // Next-state logic; a new op accepted while READY drains replaces the drain directly.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_ISSUE: if (mem_gnt)         w_next_state = S_WAIT;
      S_WAIT:  if (mem_rvalid)      w_next_state = S_READY;
      S_READY: if (w_transfer_next) w_next_state = S_EMPTY;
      default: w_next_state = r_state;
    endcase
    if (w_transfer_prev) w_next_state = w_accept_state;
  end

  // State register; reset abandons any in-flight bus transaction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_EMPTY;
    else        r_state <= w_next_state;
  end

  // Op capture on accept, and result/exception update on bus response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_store                  <= 1'b0;
      r_funct3                 <= 3'd0;
      r_ea                     <= '0;
      r_wdata                  <= '0;
      r_be                     <= 4'd0;
      r_wr_valid_in            <= 1'b0;
      program_count_out        <= '0;
      write_register_out       <= '0;
      write_register_valid_out <= 1'b0;
      writeback_data_out       <= '0;
      writeback_data_valid_out <= 1'b0;
      exception_out            <= 1'b0;
      exception_cause_out      <= CAUSE_NONE;
    end else if (w_transfer_prev) begin
      r_store            <= store_in;
      r_funct3           <= funct_3_in;
      r_ea               <= result_data_in[ADDR_WIDTH-1:0];
      r_wdata            <= f_store_lanes(funct_3_in, result_data_in[1:0], memory_store_data_in);
      r_be               <= f_byte_en(store_in, funct_3_in, result_data_in[1:0]);
      r_wr_valid_in      <= write_register_valid_in;
      program_count_out  <= program_count_in;
      write_register_out <= write_register_in;
      if (!w_is_mem) begin
        writeback_data_out       <= result_data_in;
        writeback_data_valid_out <= result_data_valid_in;
        write_register_valid_out <= write_register_valid_in;
        exception_out            <= 1'b0;
        exception_cause_out      <= CAUSE_NONE;
      end else if (!result_data_valid_in || w_illegal || w_misaligned) begin
        writeback_data_out       <= '0;
        writeback_data_valid_out <= 1'b0;
        write_register_valid_out <= 1'b0;
        exception_out            <= 1'b1;
        exception_cause_out      <= (!result_data_valid_in || w_illegal) ? CAUSE_ILLEGAL
                                                                          : CAUSE_MISALIGN;
      end else begin
        writeback_data_out       <= '0;
        writeback_data_valid_out <= 1'b0;
        write_register_valid_out <= 1'b0;
        exception_out            <= 1'b0;
        exception_cause_out      <= CAUSE_NONE;
      end
    end else if (r_state == S_WAIT && mem_rvalid) begin
      if (mem_err) begin
        writeback_data_out       <= '0;
        writeback_data_valid_out <= 1'b0;
        write_register_valid_out <= 1'b0;
        exception_out            <= 1'b1;
        exception_cause_out      <= CAUSE_ACCESS;
      end else if (r_store) begin
        writeback_data_out       <= '0;
        writeback_data_valid_out <= 1'b0;
        write_register_valid_out <= 1'b0;
      end else begin
        writeback_data_out       <= f_load_extend(r_funct3, r_ea[1:0], mem_rdata);
        writeback_data_valid_out <= 1'b1;
        write_register_valid_out <= r_wr_valid_in;
      end
    end
  end

endmodule

// File: tb/tb_memory_stage.sv
// Directed bench for memory_stage with hand-computed expectations.
module tb_memory_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall_prev, prev_done, next_stall, done_next;
  logic [31:0] program_count_in, program_count_out;
  logic        load_in, store_in;
  logic [2:0]  funct_3_in;
  logic [31:0] result_data_in, memory_store_data_in;
  logic        result_data_valid_in;
  logic [4:0]  write_register_in, write_register_out;
  logic        write_register_valid_in, write_register_valid_out;
  logic [31:0] writeback_data_out;
  logic        writeback_data_valid_out, exception_out;
  logic [1:0]  exception_cause_out;
  logic        mem_req, mem_we, mem_gnt, mem_rvalid, mem_err;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  memory_stage dut (
    .clk(clk), .rst_n(rst_n),
    .stall_prev(stall_prev), .prev_done(prev_done),
    .next_stall(next_stall), .done_next(done_next),
    .program_count_in(program_count_in), .load_in(load_in), .store_in(store_in),
    .funct_3_in(funct_3_in), .result_data_in(result_data_in),
    .result_data_valid_in(result_data_valid_in), .memory_store_data_in(memory_store_data_in),
    .write_register_in(write_register_in), .write_register_valid_in(write_register_valid_in),
    .program_count_out(program_count_out), .write_register_out(write_register_out),
    .write_register_valid_out(write_register_valid_out), .writeback_data_out(writeback_data_out),
    .writeback_data_valid_out(writeback_data_valid_out), .exception_out(exception_out),
    .exception_cause_out(exception_cause_out),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .mem_err(mem_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Present one op for a single cycle; returns 1 time unit after the accepting edge.
  task automatic send(input logic ld, input logic st, input logic [2:0] f3,
                      input logic [31:0] ea, input logic [31:0] sdata, input logic [4:0] rd);
    prev_done = 1'b1; load_in = ld; store_in = st; funct_3_in = f3;
    result_data_in = ea; result_data_valid_in = 1'b1; memory_store_data_in = sdata;
    write_register_in = rd; write_register_valid_in = 1'b1; program_count_in = ea + 32'h1000;
    @(posedge clk); #1;
    prev_done = 1'b0; load_in = 1'b0; store_in = 1'b0;
  endtask

  // Zero-wait grant followed by a response the next cycle; ends in READY.
  task automatic bus(input logic [31:0] rdata, input logic err);
    mem_gnt = 1'b1;
    @(posedge clk); #1;
    mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = rdata; mem_err = err;
    @(posedge clk); #1;
    mem_rvalid = 1'b0; mem_err = 1'b0; mem_rdata = '0;
  endtask

  task automatic drain();
    @(posedge clk); #1;
    chk("drain_done", 32'(done_next), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; prev_done = 1'b0; next_stall = 1'b0; program_count_in = '0;
    load_in = 1'b0; store_in = 1'b0; funct_3_in = '0; result_data_in = '0;
    result_data_valid_in = 1'b0; memory_store_data_in = '0; write_register_in = '0;
    write_register_valid_in = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    mem_err = 1'b0;
    #3;
    chk("rst_done", 32'(done_next), 32'd0);
    chk("rst_stall", 32'(stall_prev), 32'd1);
    chk("rst_req", 32'(mem_req), 32'd0);
    chk("rst_be", 32'(mem_be), 32'd0);
    chk("rst_exc", 32'(exception_out), 32'd0);
    chk("rst_wbv", 32'(writeback_data_valid_out), 32'd0);
    @(negedge clk); rst_n = 1'b1; #1;
    chk("idle_stall", 32'(stall_prev), 32'd0);

    // ALU forward
    @(negedge clk);
    send(1'b0, 1'b0, 3'd0, 32'h1234_5678, 32'h0, 5'd5);
    chk("alu_done", 32'(done_next), 32'd1);
    chk("alu_wb", writeback_data_out, 32'h1234_5678);
    chk("alu_wbv", 32'(writeback_data_valid_out), 32'd1);
    chk("alu_rdv", 32'(write_register_valid_out), 32'd1);
    chk("alu_rd", 32'(write_register_out), 32'd5);
    chk("alu_req", 32'(mem_req), 32'd0);
    drain();

    // LB ea=0x103
    send(1'b1, 1'b0, 3'd0, 32'h0000_0103, 32'h0, 5'd6);
    chk("lb_req", 32'(mem_req), 32'd1);
    chk("lb_addr", mem_addr, 32'h0000_0100);
    chk("lb_we", 32'(mem_we), 32'd0);
    chk("lb_be", 32'(mem_be), 32'hF);
    chk("lb_pre_done", 32'(done_next), 32'd0);
    bus(32'h80FF_0000, 1'b0);
    chk("lb_done", 32'(done_next), 32'd1);
    chk("lb_wb", writeback_data_out, 32'hFFFF_FF80);
    chk("lb_wbv", 32'(writeback_data_valid_out), 32'd1);
    chk("lb_pc", program_count_out, 32'h0000_1103);
    drain();

    // LBU ea=0x103
    send(1'b1, 1'b0, 3'd4, 32'h0000_0103, 32'h0, 5'd6);
    bus(32'h80FF_0000, 1'b0);
    chk("lbu_wb", writeback_data_out, 32'h0000_0080);
    drain();

    // LH ea=0x102 (sign) and LHU
    send(1'b1, 1'b0, 3'd1, 32'h0000_0102, 32'h0, 5'd7);
    bus(32'h8001_0000, 1'b0);
    chk("lh_wb", writeback_data_out, 32'hFFFF_8001);
    drain();
    send(1'b1, 1'b0, 3'd5, 32'h0000_0102, 32'h0, 5'd7);
    bus(32'h8001_0000, 1'b0);
    chk("lhu_wb", writeback_data_out, 32'h0000_8001);
    drain();

    // SH ea=0x202 data 0xABCD
    send(1'b0, 1'b1, 3'd1, 32'h0000_0202, 32'h0000_ABCD, 5'd8);
    chk("sh_be", 32'(mem_be), 32'hC);
    chk("sh_wdata", mem_wdata, 32'hABCD_0000);
    chk("sh_we", 32'(mem_we), 32'd1);
    chk("sh_addr", mem_addr, 32'h0000_0200);
    bus(32'hFFFF_FFFF, 1'b0);
    chk("sh_done", 32'(done_next), 32'd1);
    chk("sh_rdv", 32'(write_register_valid_out), 32'd0);
    chk("sh_wbv", 32'(writeback_data_valid_out), 32'd0);
    chk("sh_exc", 32'(exception_out), 32'd0);
    drain();

    // SB ea=0x001 data 0x5A
    send(1'b0, 1'b1, 3'd0, 32'h0000_0001, 32'hFFFF_FF5A, 5'd8);
    chk("sb_be", 32'(mem_be), 32'h2);
    chk("sb_wdata", mem_wdata, 32'h0000_5A00);
    bus(32'h0, 1'b0);
    drain();

    // LW misaligned: fault, no bus
    send(1'b1, 1'b0, 3'd2, 32'h0000_0301, 32'h0, 5'd9);
    chk("mis_done", 32'(done_next), 32'd1);
    chk("mis_exc", 32'(exception_out), 32'd1);
    chk("mis_cause", 32'(exception_cause_out), 32'd1);
    chk("mis_req", 32'(mem_req), 32'd0);
    chk("mis_rdv", 32'(write_register_valid_out), 32'd0);
    chk("mis_pc", program_count_out, 32'h0000_1301);
    drain();
    chk("mis_req2", 32'(mem_req), 32'd0);

    // Illegal load funct3
    send(1'b1, 1'b0, 3'd3, 32'h0000_0300, 32'h0, 5'd9);
    chk("ill_cause", 32'(exception_cause_out), 32'd3);
    chk("ill_req", 32'(mem_req), 32'd0);
    drain();

    // LW with access fault
    send(1'b1, 1'b0, 3'd2, 32'h0000_0400, 32'h0, 5'd10);
    bus(32'h1234_5678, 1'b1);
    chk("err_exc", 32'(exception_out), 32'd1);
    chk("err_cause", 32'(exception_cause_out), 32'd2);
    chk("err_wbv", 32'(writeback_data_valid_out), 32'd0);
    chk("err_rdv", 32'(write_register_valid_out), 32'd0);
    drain();

    // Delayed gnt/rvalid, stalled writeback, then back-to-back ALU op
    send(1'b1, 1'b0, 3'd2, 32'h0000_0500, 32'h0, 5'd11);
    for (int i = 0; i < 3; i++) begin
      chk("dly_req", 32'(mem_req), 32'd1);
      chk("dly_addr", mem_addr, 32'h0000_0500);
      @(posedge clk); #1;
    end
    chk("dly_req_g", 32'(mem_req), 32'd1);
    mem_gnt = 1'b1;
    @(posedge clk); #1;
    mem_gnt = 1'b0;
    chk("dly_req_drop", 32'(mem_req), 32'd0);
    next_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("dly_wait", 32'(done_next), 32'd0);
    end
    mem_rvalid = 1'b1; mem_rdata = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    mem_rvalid = 1'b0; mem_rdata = '0;
    for (int i = 0; i < 3; i++) begin
      chk("stl_done", 32'(done_next), 32'd1);
      chk("stl_wb", writeback_data_out, 32'hDEAD_BEEF);
      chk("stl_stall_prev", 32'(stall_prev), 32'd1);
      if (i < 2) begin @(posedge clk); #1; end
    end
    next_stall = 1'b0; #1;
    chk("b2b_stall_prev", 32'(stall_prev), 32'd0);
    send(1'b0, 1'b0, 3'd0, 32'hCAFE_F00D, 32'h0, 5'd12);
    chk("b2b_done", 32'(done_next), 32'd1);
    chk("b2b_wb", writeback_data_out, 32'hCAFE_F00D);
    drain();

    // Reset while waiting for a response
    send(1'b1, 1'b0, 3'd2, 32'h0000_0600, 32'h0, 5'd13);
    mem_gnt = 1'b1;
    @(posedge clk); #1;
    mem_gnt = 1'b0;
    #2; rst_n = 1'b0; #1;
    chk("arst_stall", 32'(stall_prev), 32'd1);
    chk("arst_done", 32'(done_next), 32'd0);
    chk("arst_req", 32'(mem_req), 32'd0);
    chk("arst_pc", program_count_out, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    mem_rvalid = 1'b1; mem_rdata = 32'h5555_AAAA;
    @(posedge clk); #1;
    mem_rvalid = 1'b0;
    chk("late_rvalid_done", 32'(done_next), 32'd0);
    chk("late_rvalid_wbv", 32'(writeback_data_valid_out), 32'd0);
    send(1'b1, 1'b0, 3'd2, 32'h0000_0700, 32'h0, 5'd14);
    chk("post_addr", mem_addr, 32'h0000_0700);
    bus(32'h1122_3344, 1'b0);
    chk("post_wb", writeback_data_out, 32'h1122_3344);
    chk("post_rd", 32'(write_register_out), 32'd14);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
